// File: rtl/alu_seq_unit.sv
// alu_seq_unit: multi-cycle handshaked ALU (iterative mul and shifts)
// Ports:
//   CLK          clock, rising edge
//   RST          asynchronous active-low reset
//   start        request, accepted only while ready
//   op1, op2     operands (op2 is also the shift amount), latched on accept
//   oprn         opcode: 01 add, 02 sub, 03 mul, 04 srl, 05 sll,
//                06 and, 07 or, 08 nor, 09 slt; anything else sets err
//   ready        high in IDLE
//   done         one-cycle pulse when result/err are valid
//   result, err  held until the next operation completes
module alu_seq_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int OPRN_WIDTH = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] op1,
    input  logic [DATA_WIDTH-1:0] op2,
    input  logic [OPRN_WIDTH-1:0] oprn,
    output logic                  ready,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  err
);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [DATA_WIDTH-1:0] W_V = DATA_WIDTH'(DATA_WIDTH);
    localparam logic [OPRN_WIDTH-1:0] OP_ADD = OPRN_WIDTH'(1);
    localparam logic [OPRN_WIDTH-1:0] OP_SUB = OPRN_WIDTH'(2);
    localparam logic [OPRN_WIDTH-1:0] OP_MUL = OPRN_WIDTH'(3);
    localparam logic [OPRN_WIDTH-1:0] OP_SRL = OPRN_WIDTH'(4);
    localparam logic [OPRN_WIDTH-1:0] OP_SLL = OPRN_WIDTH'(5);
    localparam logic [OPRN_WIDTH-1:0] OP_AND = OPRN_WIDTH'(6);
    localparam logic [OPRN_WIDTH-1:0] OP_OR  = OPRN_WIDTH'(7);
    localparam logic [OPRN_WIDTH-1:0] OP_NOR = OPRN_WIDTH'(8);
    localparam logic [OPRN_WIDTH-1:0] OP_SLT = OPRN_WIDTH'(9);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t                  state, state_nx;
    logic [CW-1:0]           cnt, n_r, n_calc;
    logic [DATA_WIDTH-1:0]   a_r, b_r, p_r, res_calc;
    logic [OPRN_WIDTH-1:0]   opc_r;
    logic                    last, bad, shift_ok;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        ready    = state == IDLE;
        done     = state == DONE;
        last     = cnt == n_r;
        state_nx = state == IDLE ? (start ? EXEC : IDLE) :
                   state == EXEC ? (last ? DONE : EXEC) : IDLE;
    end

    // Iteration count: W for mul, the shift amount for in-range shifts, else one.
    always_comb begin
        n_calc = oprn == OP_MUL ? CW'(DATA_WIDTH) :
                 ((oprn == OP_SRL || oprn == OP_SLL) && op2 != '0 && op2 < W_V) ? op2[CW-1:0] :
                 CW'(1);
    end

    always_comb begin
        shift_ok = b_r != '0 && b_r < W_V;
        bad      = opc_r == '0 || opc_r > OP_SLT;
        res_calc = '0;
        case (opc_r)
            OP_ADD:         res_calc = a_r + b_r;
            OP_SUB:         res_calc = a_r - b_r;
            OP_MUL:         res_calc = p_r;
            OP_SRL, OP_SLL: res_calc = b_r >= W_V ? '0 : a_r;
            OP_AND:         res_calc = a_r & b_r;
            OP_OR:          res_calc = a_r | b_r;
            OP_NOR:         res_calc = ~(a_r | b_r);
            OP_SLT:         res_calc = {{(DATA_WIDTH-1){1'b0}}, a_r < b_r};
            default:        res_calc = '0;
        endcase
    end

    // a_r doubles as multiplicand / shift register, b_r as multiplier (shifted out LSB first).
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            a_r    <= '0;
            b_r    <= '0;
            p_r    <= '0;
            opc_r  <= '0;
            cnt    <= '0;
            n_r    <= '0;
            result <= '0;
            err    <= 1'b0;
        end else if (state == IDLE && start) begin
            a_r   <= op1;
            b_r   <= op2;
            opc_r <= oprn;
            p_r   <= '0;
            cnt   <= '0;
            n_r   <= n_calc;
        end else if (state == EXEC) begin
            if (last) begin
                result <= res_calc;
                err    <= bad;
            end else begin
                cnt <= cnt + 1'b1;
                if (opc_r == OP_MUL) begin
                    if (b_r[0]) p_r <= p_r + a_r;
                    a_r <= a_r << 1;
                    b_r <= b_r >> 1;
                end else if (opc_r == OP_SRL && shift_ok) begin
                    a_r <= a_r >> 1;
                end else if (opc_r == OP_SLL && shift_ok) begin
                    a_r <= a_r << 1;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_seq_unit.sv
// tb_alu_seq_unit: scoreboard bench with a reference model for alu_seq_unit
module tb_alu_seq_unit;
    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        start = 1'b0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic [5:0]  oprn = '0;
    logic        ready, done, err;
    logic [31:0] result;

    typedef struct {
        logic [31:0] res;
        logic        err;
        int unsigned at;
        logic [5:0]  op;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int unsigned cyc = 0;

    alu_seq_unit dut (
        .CLK(CLK), .RST(RST), .start(start), .op1(op1), .op2(op2), .oprn(oprn),
        .ready(ready), .done(done), .result(result), .err(err)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain arithmetic; 'at' holds the iteration count N.
    function automatic exp_t model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.res = '0;
        e.err = 1'b0;
        e.at  = 1;
        e.op  = op;
        case (op)
            6'd1: e.res = a + b;
            6'd2: e.res = a - b;
            6'd3: begin e.res = a * b; e.at = 32; end
            6'd4: begin e.res = a >> b; if (b >= 1 && b <= 31) e.at = b; end
            6'd5: begin e.res = a << b; if (b >= 1 && b <= 31) e.at = b; end
            6'd6: e.res = a & b;
            6'd7: e.res = a | b;
            6'd8: e.res = ~(a | b);
            6'd9: e.res = {31'b0, a < b};
            default: e.err = 1'b1;
        endcase
        return e;
    endfunction

    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int t = 0;
        @(negedge CLK);
        start = 1'b1;
        oprn = op;
        op1 = a;
        op2 = b;
        while (!ready && t < 200) begin
            @(negedge CLK);
            t++;
        end
        if (!ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL issue_timeout: ready=%b required 1", ready);
            start = 1'b0;
            return;
        end
        e = model(op, a, b);
        // accepted on the next edge (cyc+1); done is seen N+1 edges later
        e.at = cyc + 1 + e.at + 1;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        start = 1'b0;
        op1 = $urandom;
        op2 = $urandom;
        oprn = 6'($urandom);
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(negedge CLK);
            t++;
        end
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d pending, required 0", sb.size());
            sb.delete();
        end
        repeat (2) @(negedge CLK);
    endtask

    always @(negedge CLK) begin : monitor
        exp_t e;
        if (RST && done) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL spurious_done: result=%h with nothing pending", result);
            end else begin
                e = sb.pop_front();
                chk($sformatf("result op%0h", e.op), result, e.res);
                chk($sformatf("err op%0h", e.op), {31'b0, err}, {31'b0, e.err});
                chk($sformatf("latency op%0h", e.op), cyc, e.at);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [5:0]  op;
        logic [31:0] a, b;
        repeat (2) @(negedge CLK);
        chk("reset_ready", {31'b0, ready}, 32'd1);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_err", {31'b0, err}, 32'd0);
        RST = 1'b1;

        issue(6'h01, 32'd3, 32'd13);
        issue(6'h02, 32'd3, 32'd5);
        issue(6'h03, 32'd7, 32'd7);
        issue(6'h03, 32'hFFFF_FFFF, 32'd2);
        issue(6'h04, 32'd8, 32'd1);
        issue(6'h05, 32'd1, 32'd2);
        issue(6'h05, 32'd5, 32'd0);
        issue(6'h05, 32'd5, 32'd40);
        issue(6'h06, 32'd9, 32'd9);
        issue(6'h07, 32'd5, 32'd0);
        issue(6'h08, 32'd5, 32'd8);
        issue(6'h09, 32'd16, 32'd76);
        issue(6'h09, 32'd76, 32'd16);
        issue(6'h0F, 32'd1, 32'd2);
        issue(6'h00, 32'd1, 32'd2);
        issue(6'h04, 32'h8000_0000, 32'd31);
        drain();

        issue(6'h03, 32'd7, 32'd7);
        repeat (5) begin
            @(negedge CLK);
            start = 1'b1;
            oprn = 6'h01;
            op1 = 32'd100;
            op2 = 32'd200;
            chk("busy_ready", {31'b0, ready}, 32'd0);
        end
        start = 1'b0;
        drain();
        chk("held_result", result, 32'd49);

        issue(6'h03, 32'd7, 32'd7);
        repeat (10) @(negedge CLK);
        RST = 1'b0;
        sb.delete();
        #1;
        chk("midop_reset_ready", {31'b0, ready}, 32'd1);
        chk("midop_reset_done", {31'b0, done}, 32'd0);
        chk("midop_reset_result", result, 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        issue(6'h01, 32'd20, 32'd22);
        drain();

        for (int i = 0; i < 50; i++) begin
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(10, 63)) : 6'($urandom_range(0, 9));
            a = $urandom;
            b = (op == 6'h04 || op == 6'h05) ? $urandom_range(0, 40) : $urandom;
            issue(op, a, b);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
